yarp_fetch_queue: RTL
=====================

# yarp_fetch_queue

Fetch front-end for the yarp core. Owns the fetch PC, issues one instruction-memory read per cycle, and buffers returned instruction words with their PCs in a small in-order queue. Decode consumes the queue through a valid/ready handshake. A redirect from execute (branch or jump) flushes all fetched-but-unconsumed work and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `DEPTH`, default 4: queue entries; must be a power of 2 and ≥2.

- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `redirect_i` input 1: flush and restart fetch.
- `redirect_pc_i` input 32: restart target; bits [1:0] are ignored and forced to 0.
- `fetch_req_o` output 1: memory read request this cycle.
- `fetch_addr_o` output 32: read address, equal to the fetch PC register.
- `mem_rd_data_i` input 32: read data, valid exactly 1 cycle after a request.
- `instr_valid_o` output 1: queue head is valid.
- `instr_ready_i` input 1: decode accepts the head.
- `instr_o` output 32: head instruction word.
- `instr_pc_o` output 32: head instruction PC.

## Operation
- **State**
  - `pc`: 32-bit fetch PC register.
  - `inflight`: 1 bit; a request was issued last cycle.
  - `count`: 0..DEPTH, width clog2(DEPTH)+1.
  - Circular storage of {pc, instr} with read/write pointers that wrap modulo DEPTH.
- **Issue rule**
  - `fetch_req_o = !reset && !redirect_i && (count + inflight < DEPTH)`.
  - The rule does not depend on `instr_ready_i`, so there is no combinational path from ready to request.
- **On issue**
  - `inflight <= 1`.
  - `pc <= pc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - The issued PC travels with the request so it can be stored with the returned word.
- **Response capture**
  - If `inflight` is set and there is no redirect, push {issued PC, `mem_rd_data_i`} at the write pointer.
  - Space was reserved at issue time, so the queue never overflows.
- **Pop**
  - A pop occurs when `instr_valid_o && instr_ready_i`; the read pointer advances.
- **Count**
  - Push and pop in the same cycle leave `count` unchanged.
  - Pop on an empty queue is impossible, because `instr_valid_o = (count != 0)`.
- **Head outputs**
  - `instr_o` and `instr_pc_o` are the head entry, driven from registers.
  - They are don't-care while `instr_valid_o` = 0.
- **Redirect in cycle t**
  - No request is issued in cycle t.
  - Any response arriving in cycle t is discarded.
  - `inflight <= 0`, `count <= 0`, pointers reset.
  - `pc <= {redirect_pc_i[31:2], 2'b00}`.
  - A handshake completing in cycle t counts as consumed; decode discards it on its own side.
- **Precedence**
  - `reset` overrides `redirect_i`.
  - `redirect_i` overrides issue, push and pop effects on state.

## Timing
- **Reset values**
  - `fetch_req_o` = 0, `fetch_addr_o` = `RESET_PC`, `instr_valid_o` = 0.
  - `count` = 0, `inflight` = 0, `pc` = `RESET_PC`.
- **Start-up**
  - In the first cycle with `reset` low (call it cycle 0), `fetch_req_o` = 1 and `fetch_addr_o` = `RESET_PC`.
- **Latency**
  - Request in cycle n → data in n+1 → pushed at the end of n+1 → `instr_valid_o` in n+2. Request-to-valid latency is 2 cycles.
- **Throughput**
  - With `instr_ready_i` held at 1, one instruction per cycle.
  - Steady state is `count` = 1, `inflight` = 1.
- **Backpressure**
  - With `instr_ready_i` = 0, issue stops once `count + inflight` = DEPTH.
  - Issue resumes in the cycle after the pop that frees space, because the count decrement is registered.
- **Redirect at cycle t**
  - `fetch_req_o` = 0 at t.
  - `instr_valid_o` = 0 at t+1.
  - Request for the target at t+1.
  - Target instruction valid at t+3.
- **Redirects on back-to-back cycles**: each one applies; the last one wins.
- **Reset mid-operation**
  - All state is cleared on the next edge.
  - Responses still in flight are discarded.
  - Fetch restarts at `RESET_PC` in the first cycle after release.

## Test plan
- **Reset release.** `RESET_PC` = 0, memory returns data = addr ^ 32'hA5A5_0000, ready = 1.
  - Expect requests at cycles 0, 1, 2, … with addresses 0x0, 0x4, 0x8.
  - Expect `instr_valid_o` from cycle 2, with `instr_pc_o` 0x0, 0x4, 0x8 one per cycle and matching data.
- **Backpressure.** Hold ready = 0 from reset, then release.
  - Expect exactly 4 requests (0x0–0xC), `fetch_req_o` low afterward, and `instr_valid_o` held with PC 0x0.
  - After ready = 1: heads drain in order 0x0, 0x4, 0x8, 0xC, 0x10…, with no gap, duplicate or loss.
- **Redirect.** Pulse `redirect_i` at t = 6 with target 0x100, ready = 1.
  - Expect `fetch_req_o` = 0 at t and `fetch_addr_o` = 0x100 with request at t+1.
  - Expect no valid output at t+1 and t+2, then `instr_pc_o` = 0x100 at t+3.
- **Unaligned target.** Redirect to 0x0000_0103.
  - Expect fetch address 0x100 and `instr_pc_o` 0x100.
- **Address wrap.** `RESET_PC` = 32'hFFFF_FFF8.
  - Expect addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4, and `instr_pc_o` in the same order.
- **Precedence and reset.**
  - Assert `reset` with the queue full and `redirect_i` = 1 in the same cycle: next cycle `instr_valid_o` = 0 and `fetch_req_o` = 0; after release, the first request is `RESET_PC`.

Source files
------------

// File: rtl/yarp_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect, instruction-memory port and decode handshake.
interface yarp_fetch_queue_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic [31:0] mem_rd_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  // Queue side
  modport slave (
    input  redirect_i, redirect_pc_i, mem_rd_data_i, instr_ready_i,
    output fetch_req_o, fetch_addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  // Core / memory / decode side
  modport master (
    output redirect_i, redirect_pc_i, mem_rd_data_i, instr_ready_i,
    input  fetch_req_o, fetch_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/yarp_fetch_queue.sv
// yarp fetch front-end: owns the fetch PC, issues one imem read per cycle and
// buffers {pc, instr} in an in-order circular queue drained by decode.
module yarp_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  yarp_fetch_queue_if.slave  fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   issued_pc_q;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic          req, push, pop;
  logic [CW-1:0] occupied;
  logic [31:0]   target;

  // Slots already owned: queued entries plus the response still on its way.
  // Issue never looks at instr_ready_i, so ready has no path to the request.
  assign occupied = count_q + {{(CW-1){1'b0}}, inflight_q};
  assign req      = !reset && !fq.redirect_i && (occupied < CW'(DEPTH));
  assign push     = inflight_q && !fq.redirect_i;
  assign pop      = fq.instr_valid_o && fq.instr_ready_i;
  assign target   = fq.redirect_pc_i & 32'hFFFF_FFFC;

  assign fq.fetch_req_o   = req;
  assign fq.fetch_addr_o  = pc_q;
  assign fq.instr_valid_o = (count_q != '0);
  assign fq.instr_o       = instr_mem_q[rd_ptr_q];
  assign fq.instr_pc_o    = pc_mem_q[rd_ptr_q];

  // Next state: redirect wipes everything and reloads the PC; otherwise
  // issue advances the PC, push/pop move the pointers and count.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (fq.redirect_i) begin
      pc_d       = target;
      inflight_d = 1'b0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req) pc_d = pc_q + 32'd4;
      inflight_d = req;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Control state; reset takes priority over redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // The issued PC rides alongside the request so the returning word can be tagged.
  always_ff @(posedge clk) begin
    if (req) issued_pc_q <= pc_q;
  end

  // Queue storage; no overflow check since space was reserved at issue.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]    <= issued_pc_q;
      instr_mem_q[wr_ptr_q] <= fq.mem_rd_data_i;
    end
  end
endmodule
